// File: rtl/pwm_bank.sv
// pwm_bank: multi-channel PWM generator sharing one prescaled period counter.
// Duty changes take effect only at period boundaries, so outputs never glitch.
// Optional feature macro: PWM_BANK_FADE_EN -- when defined, each channel ramps
// toward its target by at most FADE_STEP per period; otherwise the duty jumps
// straight to the target at every boundary and FADE_STEP is ignored.
module pwm_bank #(
  parameter int NUM_CHANNELS = 7,
  parameter int DUTY_WIDTH   = 8,
  parameter int PRESCALE     = 1
) (
  input  logic                               CLK,
  input  logic                               RESET,
  input  logic [NUM_CHANNELS*DUTY_WIDTH-1:0] DUTY_TARGET,
  input  logic [DUTY_WIDTH-1:0]              FADE_STEP,
  output logic [NUM_CHANNELS-1:0]            PWM_OUT,
  output logic [NUM_CHANNELS*DUTY_WIDTH-1:0] CUR_DUTY,
  output logic                               PERIOD_START,
  output logic                               FADE_DONE
);

  localparam int W     = DUTY_WIDTH;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  // Last counter value of a period: 2^W-2, so a period is 2^W-1 ticks long.
  localparam logic [W-1:0]     CNT_LAST = {{(W-1){1'b1}}, 1'b0};

  logic [PRE_W-1:0]          pre_q, pre_d;
  logic [W-1:0]              cnt_q, cnt_d;
  logic [NUM_CHANNELS*W-1:0] cur_q, cur_d;
  logic [NUM_CHANNELS-1:0]   pwm_q, pwm_d;
  logic                      period_start_q;
  logic                      fade_done_q, fade_done_d;
  logic                      tick;
  logic                      boundary;

`ifdef PWM_BANK_FADE_EN
  // One boundary's worth of movement toward the target, computed in W+1 bits
  // so neither the upward sum nor the downward limit can wrap.
  function automatic logic [W-1:0] step_duty(input logic [W-1:0] cur,
                                             input logic [W-1:0] tgt,
                                             input logic [W-1:0] step);
    logic [W:0] up_sum;
    logic [W:0] dn_limit;
    up_sum   = {1'b0, cur} + {1'b0, step};
    dn_limit = {1'b0, tgt} + {1'b0, step};
    if (step == '0 || cur == tgt) return tgt;
    else if (cur < tgt)           return (up_sum >= {1'b0, tgt}) ? tgt : up_sum[W-1:0];
    else                          return (dn_limit >= {1'b0, cur}) ? tgt : cur - step;
  endfunction
`else
  // FADE_STEP has no function without fading; fold it into a sink.
  logic unused_fade_step;
  assign unused_fade_step = ^FADE_STEP;
`endif

  // Shared prescaler and period counter; boundary marks the last tick of a period.
  always_comb begin
    tick     = (pre_q == PRE_LAST);
    pre_d    = tick ? '0 : pre_q + PRE_W'(1);
    boundary = tick && (cnt_q == CNT_LAST);
    cnt_d    = cnt_q;
    if (tick) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + W'(1);
  end

  // Per-channel duty update at boundaries, PWM compare and all-channels-done flag.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch is inferred.
    cur_d       = cur_q;
    pwm_d       = '0;
    fade_done_d = 1'b1;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (boundary) begin
`ifdef PWM_BANK_FADE_EN
        cur_d[i*W +: W] = step_duty(cur_q[i*W +: W], DUTY_TARGET[i*W +: W], FADE_STEP);
`else
        cur_d[i*W +: W] = DUTY_TARGET[i*W +: W];
`endif
      end
      pwm_d[i] = (cnt_q < cur_q[i*W +: W]);
      if (cur_d[i*W +: W] != DUTY_TARGET[i*W +: W]) fade_done_d = 1'b0;
    end
  end

  // State registers; a synchronous reset aborts the current period and any fade.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (RESET) begin
      pre_q          <= '0;
      cnt_q          <= '0;
      cur_q          <= '0;
      pwm_q          <= '0;
      period_start_q <= 1'b0;
      fade_done_q    <= 1'b1;
    end else begin
      pre_q          <= pre_d;
      cnt_q          <= cnt_d;
      cur_q          <= cur_d;
      pwm_q          <= pwm_d;
      period_start_q <= boundary;
      fade_done_q    <= fade_done_d;
    end
  end

  assign PWM_OUT      = pwm_q;
  assign CUR_DUTY     = cur_q;
  assign PERIOD_START = period_start_q;
  assign FADE_DONE    = fade_done_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Directed testbench for pwm_bank: 4 channels, 8-bit duty, PRESCALE 1 (dut)
// plus a PRESCALE 3 instance (dut3). Fade checks follow PWM_BANK_FADE_EN.
module tb_pwm_bank;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             CLK = 1'b0;
  logic             RESET = 1'b1;
  logic [NCH*W-1:0] duty_target;
  logic [W-1:0]     fade_step;
  logic [NCH-1:0]   pwm_out;
  logic [NCH*W-1:0] cur_duty;
  logic             period_start;
  logic             fade_done;

  logic [NCH*W-1:0] duty_target3;
  logic [W-1:0]     fade_step3;
  logic [NCH-1:0]   pwm_out3;
  logic [NCH*W-1:0] cur_duty3;
  logic             period_start3;
  logic             fade_done3;

  int n_checks = 0;
  int n_errors = 0;
  int hi[NCH];

  pwm_bank #(.NUM_CHANNELS(NCH), .DUTY_WIDTH(W), .PRESCALE(1)) dut (
    .CLK(CLK), .RESET(RESET), .DUTY_TARGET(duty_target), .FADE_STEP(fade_step),
    .PWM_OUT(pwm_out), .CUR_DUTY(cur_duty), .PERIOD_START(period_start),
    .FADE_DONE(fade_done)
  );

  pwm_bank #(.NUM_CHANNELS(NCH), .DUTY_WIDTH(W), .PRESCALE(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .DUTY_TARGET(duty_target3), .FADE_STEP(fade_step3),
    .PWM_OUT(pwm_out3), .CUR_DUTY(cur_duty3), .PERIOD_START(period_start3),
    .FADE_DONE(fade_done3)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    repeat (n) step();
    RESET = 1'b0;
  endtask

  task automatic set_t(input int ch, input logic [W-1:0] v);
    duty_target[ch*W +: W] = v;
  endtask

  function automatic logic [W-1:0] cur_of(input int ch);
    return cur_duty[ch*W +: W];
  endfunction

  // Step until PERIOD_START is seen; waited returns the number of cycles taken.
  task automatic wait_ps(input string tag, output int waited);
    logic found;
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < 1000; i++) begin
      step();
      waited++;
      if (period_start) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_wait"}, found, 1);
  endtask

  // Count high cycles per channel over one full period starting at a boundary;
  // optionally change one target when the counter reads chg_at.
  task automatic measure(input int chg_at, input int ch, input logic [W-1:0] v);
    for (int c = 0; c < NCH; c++) hi[c] = 0;
    for (int j = 1; j <= 255; j++) begin
      step();
      if (j == chg_at) set_t(ch, v);
      for (int c = 0; c < NCH; c++) if (pwm_out[c]) hi[c]++;
    end
  endtask

  initial begin
    int waited;
    int ps_count, ps_first, ps_last, pwm_bad, fd_bad;
    int gap, hi3, run, max_run;
    logic found;
`ifdef PWM_BANK_FADE_EN
    int exp_up[7]   = '{16, 32, 48, 64, 80, 96, 100};
    int exp_down[7] = '{84, 68, 52, 36, 20, 4, 0};
`endif

    duty_target  = '0;
    fade_step    = '0;
    duty_target3 = '0;
    duty_target3[0 +: W] = 8'd128;
    fade_step3   = '0;

    // Scenario 1: reset state, then three idle periods.
    do_reset(3);
    check("rst_cur_duty", cur_duty, 0);
    check("rst_pwm_out", pwm_out, 0);
    check("rst_period_start", period_start, 0);
    check("rst_fade_done", fade_done, 1);

    ps_count = 0; ps_first = 0; ps_last = 0; pwm_bad = 0; fd_bad = 0;
    for (int n = 1; n <= 765; n++) begin
      step();
      if (pwm_out != '0) pwm_bad++;
      if (fade_done !== 1'b1) fd_bad++;
      if (period_start) begin
        ps_count++;
        if (ps_first == 0) ps_first = n;
        ps_last = n;
      end
    end
    check("s1_pwm_high_cycles", pwm_bad, 0);
    check("s1_fade_done_low_cycles", fd_bad, 0);
    check("s1_period_start_count", ps_count, 3);
    check("s1_first_boundary", ps_first, 255);
    check("s1_last_boundary", ps_last, 765);

    // Scenario 2: direct duties including both extremes.
    set_t(0, 8'd255); set_t(1, 8'd0); set_t(2, 8'd128); set_t(3, 8'd1);
    wait_ps("s2_boundary", waited);
    check("s2_boundary_spacing", waited, 255);
    check("s2_cur_duty", cur_duty, 32'h0180_00FF);
    check("s2_fade_done", fade_done, 1);
    measure(-1, 0, 8'd0);
    check("s2_ch0_high", hi[0], 255);
    check("s2_ch1_high", hi[1], 0);
    check("s2_ch2_high", hi[2], 128);
    check("s2_ch3_high", hi[3], 1);
    check("s2_next_period_start", period_start, 1);

    // Scenario 4: mid-period target change waits for the next boundary.
    measure(50, 2, 8'd40);
    check("s4_ch2_high_current", hi[2], 128);
    check("s4_ch2_cur_after_boundary", cur_of(2), 40);
    measure(-1, 0, 8'd0);
    check("s4_ch2_high_next", hi[2], 40);
    check("s4_ch0_high_next", hi[0], 255);

    // Scenario 3: fade 0 -> 100 -> 0 with step 16.
    do_reset(1);
    duty_target = '0;
    set_t(0, 8'd100);
    fade_step = 8'd16;
    step();
    check("s3_fade_done_pending", fade_done, 0);
`ifdef PWM_BANK_FADE_EN
    for (int k = 0; k < 7; k++) begin
      wait_ps("s3_up", waited);
      check($sformatf("s3_up_cur_%0d", k), cur_of(0), exp_up[k]);
      check($sformatf("s3_up_done_%0d", k), fade_done, (k == 6) ? 1 : 0);
    end
    set_t(0, 8'd0);
    for (int k = 0; k < 7; k++) begin
      wait_ps("s3_down", waited);
      check($sformatf("s3_down_cur_%0d", k), cur_of(0), exp_down[k]);
      check($sformatf("s3_down_done_%0d", k), fade_done, (k == 6) ? 1 : 0);
    end
`else
    wait_ps("s3_jump", waited);
    check("s3_jump_cur", cur_of(0), 100);
    check("s3_jump_done", fade_done, 1);
`endif

    // Scenario 6: reset pulse in the middle of a fade.
    do_reset(1);
    duty_target = '0;
    set_t(0, 8'd100);
    fade_step = 8'd16;
`ifdef PWM_BANK_FADE_EN
    repeat (3) wait_ps("s6_fade", waited);
    check("s6_cur_before_reset", cur_of(0), 48);
`else
    wait_ps("s6_jump", waited);
    check("s6_cur_before_reset", cur_of(0), 100);
`endif
    repeat (20) step();
    check("s6_pwm_before_reset", pwm_out[0], 1);
    do_reset(1);
    check("s6_rst_cur_duty", cur_duty, 0);
    check("s6_rst_pwm_out", pwm_out, 0);
    check("s6_rst_fade_done", fade_done, 1);
    wait_ps("s6_first_boundary", waited);
    check("s6_first_boundary_delay", waited, 255);

    // Scenario 5: PRESCALE 3 instance, ch0 duty 128.
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (period_start3) begin
        found = 1'b1;
        break;
      end
    end
    check("s5_first_boundary_wait", found, 1);
    check("s5_cur_duty", cur_duty3[0 +: W], 128);
    gap = 0; hi3 = 0; run = 0; max_run = 0; found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      gap++;
      if (pwm_out3[0]) begin
        hi3++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (period_start3) begin
        found = 1'b1;
        break;
      end
    end
    check("s5_second_boundary_wait", found, 1);
    check("s5_period_spacing", gap, 765);
    check("s5_ch0_high", hi3, 384);
    check("s5_ch0_consecutive", max_run, 384);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
